// File: rtl/irq_ack_sequencer_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
// Sequencer states, bus/channel geometry, vector field widths and the line index helper.
package irq_pkg;

  localparam int N_BUS  = 3;
  localparam int N_CHAN = 9;
  localparam int N_LINE = N_BUS * N_CHAN;
  localparam int BUS_W  = 2;
  localparam int CHAN_W = 4;
  localparam int VEC_W  = BUS_W + CHAN_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2,
    SERVICE = 2'd3
  } state_e;

  // Flat request-line index of a {bus, chan} pair.
  function automatic int unsigned onehot_idx(input logic [BUS_W-1:0]  bus,
                                             input logic [CHAN_W-1:0] chan);
    return (int'(bus) * N_CHAN) + int'(chan);
  endfunction

endpackage

// File: rtl/irq_ack_sequencer_if.sv
// Controller/device/CPU side signals of the acknowledge sequencer.
// slave = sequencer side, master = controller/device/CPU side.
interface irq_ack_sequencer_if;
  import irq_pkg::*;

  logic [N_BUS-1:0]  bus_vld_i;
  logic [CHAN_W-1:0] chan_i;
  logic [N_LINE-1:0] req_i;
  logic              eoi_i;
  logic [N_LINE-1:0] ack_o;
  logic [N_LINE-1:0] mask_o;
  logic [VEC_W-1:0]  vec_o;
  logic              irq_o;
  logic              err_o;

  modport slave (
    input  bus_vld_i, chan_i, req_i, eoi_i,
    output ack_o, mask_o, vec_o, irq_o, err_o
  );

  modport master (
    output bus_vld_i, chan_i, req_i, eoi_i,
    input  ack_o, mask_o, vec_o, irq_o, err_o
  );

endinterface

// File: rtl/irq_ack_sequencer_dec.sv
// {bus, chan} to one-hot line decoder with an in-range flag.
// Out-of-range codes give an all-zero vector so they can never acknowledge a line.
module irq_onehot_dec
  import irq_pkg::*;
(
  input  logic [BUS_W-1:0]  bus_i,
  input  logic [CHAN_W-1:0] chan_i,
  output logic [N_LINE-1:0] onehot_o,
  output logic              in_range_o
);

  // Range check, then a single-bit shift into the flat line vector.
  always_comb begin
    in_range_o = (int'(bus_i) < N_BUS) && (int'(chan_i) < N_CHAN);
    onehot_o   = '0;
    if (in_range_o) begin
      onehot_o = N_LINE'(1) << onehot_idx(bus_i, chan_i);
    end
  end

endmodule

// File: rtl/irq_ack_sequencer.sv
// Responder side of the 3-bus priority interrupt controller: decodes the winning
// bus/channel, runs the ack/release handshake and holds the in-service mask until EOI.
//
// State | meaning
// IDLE    | waiting for a bus flag; outputs from the last service kept except ack
// ACK     | one-hot ack driven for one cycle, mask bit and irq already set
// RELEASE | ack held until the device drops its request line
// SERVICE | irq high, mask bit held until the CPU issues EOI
//
// Optional build macro IRQ_TIMEOUT_EN: bounds RELEASE with a TMO_W down-counter.
module irq_ack_sequencer
  import irq_pkg::*;
`ifdef IRQ_TIMEOUT_EN
  #(parameter int TMO_W = 8)
`endif
(
  input  logic                clk,
  input  logic                rst_n,
  irq_ack_sequencer_if.slave  bus_if
);

  state_e            state_q;
  logic [BUS_W-1:0]  bus_q;
  logic [CHAN_W-1:0] chan_q;
  logic [N_LINE-1:0] ack_q;
  logic [N_LINE-1:0] mask_q;
  logic              irq_q;
  logic              err_q;
`ifdef IRQ_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_q;
`endif

  logic [BUS_W-1:0]  pri_bus;
  logic [BUS_W-1:0]  dec_bus;
  logic [CHAN_W-1:0] dec_chan;
  logic [N_LINE-1:0] dec_onehot;
  logic              dec_in_range;
  logic              req_held;

  // Lowest set bus flag wins; the decoder sees live inputs in IDLE and the latched pair otherwise.
  always_comb begin
    pri_bus = '0;
    for (int b = N_BUS - 1; b >= 0; b--) begin
      if (bus_if.bus_vld_i[b]) pri_bus = BUS_W'(b);
    end
    dec_bus  = (state_q == IDLE) ? pri_bus       : bus_q;
    dec_chan = (state_q == IDLE) ? bus_if.chan_i : chan_q;
  end

  irq_onehot_dec u_dec (
    .bus_i      (dec_bus),
    .chan_i     (dec_chan),
    .onehot_o   (dec_onehot),
    .in_range_o (dec_in_range)
  );

  // ack_q is one-hot during RELEASE, so this is the acknowledged device's request line.
  assign req_held = |(bus_if.req_i & ack_q);

  // Handshake sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bus_q   <= '0;
      chan_q  <= '0;
      ack_q   <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      // EOI is only legal in SERVICE; anywhere else (including alongside a req drop) it is early.
      if (bus_if.eoi_i && (state_q != SERVICE)) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (|bus_if.bus_vld_i) begin
            if (!dec_in_range) begin
              err_q <= 1'b1;
            end else begin
              bus_q   <= pri_bus;
              chan_q  <= bus_if.chan_i;
              ack_q   <= dec_onehot;
              mask_q  <= mask_q | dec_onehot;
              irq_q   <= 1'b1;
              state_q <= ACK;
            end
          end
        end
        ACK: begin
          state_q <= RELEASE;
`ifdef IRQ_TIMEOUT_EN
          tmo_q   <= '1;
`endif
        end
        RELEASE: begin
          if (!req_held) begin
            ack_q   <= '0;
            state_q <= SERVICE;
          end
`ifdef IRQ_TIMEOUT_EN
          else if (tmo_q == '0) begin
            // Device never released: drop ack but keep the line masked until EOI.
            ack_q   <= '0;
            err_q   <= 1'b1;
            state_q <= SERVICE;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
`endif
        end
        SERVICE: begin
          if (bus_if.eoi_i) begin
            mask_q  <= mask_q & ~dec_onehot;
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.ack_o  = ack_q;
  assign bus_if.mask_o = mask_q;
  assign bus_if.vec_o  = {bus_q, chan_q};
  assign bus_if.irq_o  = irq_q;
  assign bus_if.err_o  = err_q;

endmodule

// File: tb/tb_irq_ack_sequencer.sv
// Directed bench for irq_ack_sequencer: reset mid-handshake, bus priority,
// out-of-range channel, stray/early EOI and (with IRQ_TIMEOUT_EN) the release timeout.
module tb_irq_ack_sequencer;
  import irq_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  irq_ack_sequencer_if bif ();

`ifdef IRQ_TIMEOUT_EN
  irq_ack_sequencer #(.TMO_W(4)) dut (
`else
  irq_ack_sequencer dut (
`endif
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bif.bus_vld_i = '0;
    bif.chan_i    = '0;
    bif.req_i     = '0;
    bif.eoi_i     = 1'b0;
    tick();
    tick();
    chk("rst_ack",  32'(bif.ack_o),  32'h0);
    chk("rst_mask", 32'(bif.mask_o), 32'h0);
    chk("rst_err",  32'(bif.err_o),  32'h0);

    // Reset while in RELEASE with ack_o[5] high.
    rst_n = 1'b1;
    bif.bus_vld_i = 3'b001;
    bif.chan_i    = 4'd5;
    bif.req_i     = 27'(1) << 5;
    tick();
    bif.bus_vld_i = '0;
    tick();
    chk("t1_ack_pre", 32'(bif.ack_o),  32'h20);
    chk("t1_vec_pre", 32'(bif.vec_o),  32'h05);
    rst_n = 1'b0;
    tick();
    chk("t1_ack",  32'(bif.ack_o),  32'h0);
    chk("t1_mask", 32'(bif.mask_o), 32'h0);
    chk("t1_vec",  32'(bif.vec_o),  32'h0);
    chk("t1_irq",  32'(bif.irq_o),  32'h0);
    chk("t1_err",  32'(bif.err_o),  32'h0);
    rst_n = 1'b1;
    tick();
    chk("t1_idle_ack", 32'(bif.ack_o), 32'h0);
    bif.req_i = '0;

    // Bus B, channel 4 -> line 13, full handshake.
    bif.bus_vld_i = 3'b010;
    bif.chan_i    = 4'd4;
    bif.req_i     = 27'(1) << 13;
    tick();
    chk("t2_ack",  32'(bif.ack_o),  32'h2000);
    chk("t2_vec",  32'(bif.vec_o),  32'h14);
    chk("t2_mask", 32'(bif.mask_o), 32'h2000);
    chk("t2_irq",  32'(bif.irq_o),  32'h1);
    bif.bus_vld_i = '0;
    tick();
    tick();
    chk("t2_ack_held", 32'(bif.ack_o), 32'h2000);
    bif.req_i = '0;
    tick();
    chk("t2_ack_drop", 32'(bif.ack_o),  32'h0);
    chk("t2_svc_mask", 32'(bif.mask_o), 32'h2000);
    chk("t2_svc_irq",  32'(bif.irq_o),  32'h1);
    tick();
    bif.eoi_i = 1'b1;
    tick();
    bif.eoi_i = 1'b0;
    chk("t2_eoi_mask", 32'(bif.mask_o), 32'h0);
    chk("t2_eoi_irq",  32'(bif.irq_o),  32'h0);
    chk("t2_eoi_vec",  32'(bif.vec_o),  32'h14);
    chk("t2_err",      32'(bif.err_o),  32'h0);

    // All buses requesting: bus A wins; later bus flag changes are ignored.
    bif.bus_vld_i = 3'b111;
    bif.chan_i    = 4'd2;
    bif.req_i     = 27'(1) << 2;
    tick();
    chk("t3_ack", 32'(bif.ack_o), 32'h4);
    chk("t3_vec", 32'(bif.vec_o), 32'h02);
    bif.bus_vld_i = 3'b010;
    bif.chan_i    = 4'd7;
    tick();
    tick();
    chk("t3_ack_kept", 32'(bif.ack_o), 32'h4);
    chk("t3_vec_kept", 32'(bif.vec_o), 32'h02);
    bif.req_i     = '0;
    bif.bus_vld_i = '0;
    tick();
    chk("t3_ack_drop", 32'(bif.ack_o), 32'h0);
    bif.eoi_i = 1'b1;
    tick();
    bif.eoi_i = 1'b0;
    chk("t3_mask", 32'(bif.mask_o), 32'h0);
    chk("t3_err",  32'(bif.err_o),  32'h0);

    // Out-of-range channel codes.
    bif.bus_vld_i = 3'b001;
    bif.chan_i    = 4'd12;
    tick();
    chk("t4_err",  32'(bif.err_o), 32'h1);
    chk("t4_ack",  32'(bif.ack_o), 32'h0);
    chk("t4_irq",  32'(bif.irq_o), 32'h0);
    bif.bus_vld_i = '0;
    tick();
    chk("t4_idle", 32'(bif.ack_o), 32'h0);
    do_reset();
    bif.bus_vld_i = 3'b010;
    bif.chan_i    = 4'd9;
    tick();
    bif.bus_vld_i = '0;
    chk("t4b_err", 32'(bif.err_o), 32'h1);
    chk("t4b_ack", 32'(bif.ack_o), 32'h0);

    // Stray EOI in IDLE.
    do_reset();
    bif.eoi_i = 1'b1;
    tick();
    bif.eoi_i = 1'b0;
    chk("t5_err",  32'(bif.err_o),  32'h1);
    chk("t5_mask", 32'(bif.mask_o), 32'h0);
    chk("t5_irq",  32'(bif.irq_o),  32'h0);

    // Bus C, top channel 8 -> line 26; EOI coinciding with the request drop is early.
    do_reset();
    bif.bus_vld_i = 3'b100;
    bif.chan_i    = 4'd8;
    bif.req_i     = 27'(1) << 26;
    tick();
    bif.bus_vld_i = '0;
    chk("t7_ack", 32'(bif.ack_o), 32'h4000000);
    chk("t7_vec", 32'(bif.vec_o), 32'h28);
    chk("t7_err", 32'(bif.err_o), 32'h0);
    tick();
    bif.req_i = '0;
    bif.eoi_i = 1'b1;
    tick();
    bif.eoi_i = 1'b0;
    chk("t7_ack_drop", 32'(bif.ack_o),  32'h0);
    chk("t7_err_set",  32'(bif.err_o),  32'h1);
    chk("t7_mask",     32'(bif.mask_o), 32'h4000000);
    tick();
    chk("t7_irq_held", 32'(bif.irq_o), 32'h1);
    bif.eoi_i = 1'b1;
    tick();
    bif.eoi_i = 1'b0;
    chk("t7_eoi_mask", 32'(bif.mask_o), 32'h0);
    chk("t7_eoi_irq",  32'(bif.irq_o),  32'h0);

`ifdef IRQ_TIMEOUT_EN
    // Device never releases line 0: ack drops after the counter expires.
    begin
      int n;
      do_reset();
      bif.bus_vld_i = 3'b001;
      bif.chan_i    = 4'd0;
      bif.req_i     = 27'h1;
      tick();
      bif.bus_vld_i = '0;
      n = 0;
      while (bif.ack_o != '0 && n < 40) begin
        tick();
        n++;
      end
      chk("t6_ack_drop", 32'(bif.ack_o),  32'h0);
      chk("t6_cycles",   32'(n),          32'd17);
      chk("t6_err",      32'(bif.err_o),  32'h1);
      chk("t6_mask",     32'(bif.mask_o), 32'h1);
      bif.req_i = '0;
      bif.eoi_i = 1'b1;
      tick();
      bif.eoi_i = 1'b0;
      chk("t6_eoi_mask", 32'(bif.mask_o), 32'h0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
